// File: rtl/coeff_loader_pkg.sv
// Shared definitions for the coefficient loader and the coefficient memory.
// Contents:
//   state_t         loader FSM state encoding (IDLE, LOAD, DONE)
//   addr_width()    address width for a given coefficient count
//   sum_width()     checksum width that cannot overflow for a full load
package coeff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // One extra bit so the count can reach LENGTH without wrapping.
    function automatic int addr_width(input int length);
        return $clog2(length) + 1;
    endfunction

    function automatic int sum_width(input int width, input int length);
        return width + $clog2(length);
    endfunction

endpackage

// File: rtl/coeff_loader.sv
// Coefficient loader: accepts a stream of LENGTH signed coefficients and
// writes them to the coefficient RAM at addresses 0..LENGTH-1 in arrival
// order, accumulating a signed checksum of the accepted words.
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   start               begin a load (honoured only in IDLE)
//   abort               cancel an in-progress load
//   in_data/in_valid    coefficient stream input
//   in_ready            loader accepts in_data this cycle
//   wr_en/wr_addr/wr_data  registered RAM write port
//   busy                high while loading
//   done                one-cycle pulse on load completion
//   count               words accepted in the current/last load
//   checksum            signed sum of accepted words
module coeff_loader
    import coeff_loader_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LENGTH = 64,
    parameter int ADDR_W = addr_width(LENGTH),
    parameter int SUM_W  = sum_width(WIDTH, LENGTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] count,
    output logic [SUM_W-1:0]  checksum
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LENGTH - 1);

    state_t state, state_next;
    logic   accept;
    logic   load_start;

    // abort wins over a simultaneous handshake.
    assign accept     = (state == LOAD) && in_valid && !abort;
    assign load_start = (state == IDLE) && start;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (abort)
                    state_next = IDLE;
                else if (accept && count == LAST_IDX)
                    state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            count    <= '0;
            checksum <= '0;
        end else begin
            state <= state_next;
            wr_en <= accept;
            if (load_start) begin
                count    <= '0;
                checksum <= '0;
            end else if (accept) begin
                wr_addr  <= count;
                wr_data  <= in_data;
                count    <= count + ADDR_W'(1);
                checksum <= checksum + {{(SUM_W-WIDTH){in_data[WIDTH-1]}}, in_data};
            end
        end
    end

endmodule
